// File: rtl/elevator_pkg.sv
// Shared elevator constants, floor index type and the scheduler direction/state enum.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef logic [FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/floor_search.sv
// Combinational search of a pending mask for the nearest set floor above and below a reference floor.
module floor_search #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W    = 3
) (
  input  logic [NUM_FLOORS-1:0] mask,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  above_any,
  output logic                  below_any,
  output logic [FLOOR_W-1:0]    nearest_above,
  output logic [FLOOR_W-1:0]    nearest_below
);

  always_comb begin
    above_any     = 1'b0;
    below_any     = 1'b0;
    nearest_above = '0;
    nearest_below = '0;
    // Descending scan so the last hit is the lowest floor above the car.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(current_floor))) begin
        above_any     = 1'b1;
        nearest_above = FLOOR_W'(i);
      end
    end
    // Ascending scan so the last hit is the highest floor below the car.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (mask[i] && (i < int'(current_floor))) begin
        below_any     = 1'b1;
        nearest_below = FLOOR_W'(i);
      end
    end
  end

endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN floor request scheduler: latches call buttons, sweeps UP/DOWN and issues the next target floor.
// Optional return-to-floor-0 parking after an idle timeout is enabled with `define PARK_HOME_EN.
module floor_request_scheduler #(
  parameter int NUM_FLOORS   = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W      = elevator_pkg::FLOOR_W,
  parameter int PARK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_stopped,
  output logic [FLOOR_W-1:0]    requested_floor,
  output logic                  req_valid,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);

  import elevator_pkg::*;

  state_t                  state, state_next;
  logic [NUM_FLOORS-1:0]   pending_next;
  logic [NUM_FLOORS-1:0]   clr_mask;
  logic [NUM_FLOORS-1:0]   park_mask;
  logic                    here;
  logic                    above_any, below_any;
  logic [FLOOR_W-1:0]      nearest_above, nearest_below;
  logic [FLOOR_W-1:0]      target_next;
  logic                    valid_next;

  floor_search #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_search (
    .mask          (pending),
    .current_floor (current_floor),
    .above_any     (above_any),
    .below_any     (below_any),
    .nearest_above (nearest_above),
    .nearest_below (nearest_below)
  );

  // An out-of-range current_floor matches no bit, so nothing is cleared and here stays 0.
  always_comb begin
    clr_mask = '0;
    here     = 1'b0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (int'(current_floor) == f) begin
        here        = pending[f];
        clr_mask[f] = car_stopped;
      end
    end
  end

  assign pending_next = (pending | call_btn | park_mask) & ~clr_mask;

`ifdef PARK_HOME_EN
  localparam int CNT_W = $clog2(PARK_TIMEOUT + 1);

  logic [CNT_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || (|call_btn) || (state != IDLE)) begin
      idle_cnt <= '0;
    end else if ((pending == '0) && (current_floor != '0) &&
                 (idle_cnt != CNT_W'(PARK_TIMEOUT))) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign park_mask = {{(NUM_FLOORS-1){1'b0}}, (idle_cnt == CNT_W'(PARK_TIMEOUT))};
`else
  assign park_mask = '0;
`endif

  // Target is chosen against the direction being entered so it lines up with the new state.
  always_comb begin
    state_next  = state;
    target_next = current_floor;
    valid_next  = 1'b0;
    unique case (state)
      IDLE: begin
        if (above_any)      state_next = UP;
        else if (below_any) state_next = DOWN;
        else                state_next = IDLE;
      end
      UP: begin
        if (above_any)      state_next = UP;
        else if (below_any) state_next = DOWN;
        else                state_next = IDLE;
      end
      DOWN: begin
        if (below_any)      state_next = DOWN;
        else if (above_any) state_next = UP;
        else                state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    unique case (state_next)
      UP: begin
        target_next = nearest_above;
        valid_next  = 1'b1;
      end
      DOWN: begin
        target_next = nearest_below;
        valid_next  = 1'b1;
      end
      default: begin
        target_next = current_floor;
        valid_next  = here;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pending         <= '0;
      requested_floor <= '0;
      req_valid       <= 1'b0;
    end else begin
      state           <= state_next;
      pending         <= pending_next;
      requested_floor <= target_next;
      req_valid       <= valid_next;
    end
  end

  assign dir_up = (state == UP);
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed testbench for floor_request_scheduler (default build, parking feature disabled).
module tb_floor_request_scheduler;

  logic       clk;
  logic       rst;
  logic [7:0] call_btn;
  logic [2:0] current_floor;
  logic       car_stopped;
  logic [2:0] requested_floor;
  logic       req_valid;
  logic [7:0] pending;
  logic       dir_up;
  logic       busy;

  int checks = 0;
  int errors = 0;

  floor_request_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .call_btn        (call_btn),
    .current_floor   (current_floor),
    .car_stopped     (car_stopped),
    .requested_floor (requested_floor),
    .req_valid       (req_valid),
    .pending         (pending),
    .dir_up          (dir_up),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1ns later, inputs changed there too.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pend, input logic [2:0] e_req,
                           input logic e_valid, input logic e_up, input logic e_busy);
    check({tag, ".pending"},         32'(pending),         32'(e_pend));
    check({tag, ".requested_floor"}, 32'(requested_floor), 32'(e_req));
    check({tag, ".req_valid"},       32'(req_valid),       32'(e_valid));
    check({tag, ".dir_up"},          32'(dir_up),          32'(e_up));
    check({tag, ".busy"},            32'(busy),            32'(e_busy));
  endtask

  initial begin
    rst           = 1'b1;
    call_btn      = '0;
    current_floor = 3'd0;
    car_stopped   = 1'b0;
    step(2);
    check_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Quiet after reset.
    for (int i = 0; i < 10; i++) begin
      step();
      check_all("quiet", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    end

    // Floors 2 and 5 pressed together from floor 0.
    call_btn = 8'b0010_0100;
    step();
    call_btn = '0;
    check_all("press25.k", 8'h24, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("press25.k1", 8'h24, 3'd2, 1'b1, 1'b1, 1'b1);
    current_floor = 3'd2;
    car_stopped   = 1'b1;
    step();
    check_all("stop2", 8'h20, 3'd5, 1'b1, 1'b1, 1'b1);
    car_stopped = 1'b0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("rst2", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Sweep from floor 3 toward 6, then a nearer press at 4 and a behind press at 1.
    current_floor = 3'd3;
    call_btn      = 8'h40;
    step();
    call_btn = '0;
    step();
    check_all("up6", 8'h40, 3'd6, 1'b1, 1'b1, 1'b1);
    call_btn = 8'h10;
    step();
    call_btn = '0;
    check_all("press4.k", 8'h50, 3'd6, 1'b1, 1'b1, 1'b1);
    step();
    check_all("press4.k1", 8'h50, 3'd4, 1'b1, 1'b1, 1'b1);
    call_btn = 8'h02;
    step();
    call_btn = '0;
    step();
    check_all("press1", 8'h52, 3'd4, 1'b1, 1'b1, 1'b1);
    current_floor = 3'd4;
    car_stopped   = 1'b1;
    step();
    check_all("stop4", 8'h42, 3'd6, 1'b1, 1'b1, 1'b1);
    current_floor = 3'd6;
    step();
    check_all("stop6", 8'h02, 3'd1, 1'b1, 1'b0, 1'b1);
    current_floor = 3'd1;
    step();
    check_all("stop1", 8'h00, 3'd1, 1'b1, 1'b0, 1'b0);
    step();
    check_all("idle1", 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);

    // Press of the floor the car is stopped at is dropped (clear beats set).
    current_floor = 3'd4;
    call_btn      = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("hold4", 8'h00, 3'd4, 1'b0, 1'b0, 1'b0);
    end
    call_btn    = '0;
    car_stopped = 1'b0;

    // Top floor: a press there is never "above", car stays IDLE with a valid here-target.
    current_floor = 3'd7;
    call_btn      = 8'h80;
    step();
    call_btn = '0;
    step();
    check_all("top7", 8'h80, 3'd7, 1'b1, 1'b0, 1'b0);
    car_stopped = 1'b1;
    step();
    check_all("top7.clr", 8'h00, 3'd7, 1'b1, 1'b0, 1'b0);
    car_stopped = 1'b0;

    // Bottom floor: floor 0 pressed from floor 0 is here, not below.
    current_floor = 3'd0;
    call_btn      = 8'h01;
    step();
    call_btn = '0;
    step();
    check_all("bot0", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);
    car_stopped = 1'b1;
    step();
    car_stopped = 1'b0;
    step();
    check_all("bot0.clr", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of an UP sweep drops everything.
    call_btn = 8'b1001_0000;
    step();
    call_btn = '0;
    step();
    check_all("sweep", 8'h90, 3'd4, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("midrst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step();
    check_all("postrst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

    // Without parking, an idle car at floor 3 stays put.
    current_floor = 3'd3;
    step(100);
    check_all("nopark", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
